// File: rtl/psram_arbiter_if.sv
// Requester, engine and status signals of the PSRAM arbiter.
// slave: arbiter side. master: the requesters and the burst engine.
interface psram_arbiter_if;
  logic        req0;
  logic [21:0] addr0;
  logic        gnt0;
  logic        done0;
  logic        req1;
  logic [21:0] addr1;
  logic        gnt1;
  logic        done1;
  logic        eng_start;
  logic [21:0] eng_addr;
  logic        eng_owner;
  logic        eng_done;
  logic        err_timeout;
  logic        busy;

  modport slave (
    input  req0, addr0, req1, addr1, eng_done,
    output gnt0, done0, gnt1, done1, eng_start, eng_addr, eng_owner, err_timeout, busy
  );

  modport master (
    output req0, addr0, req1, addr1, eng_done,
    input  gnt0, done0, gnt1, done1, eng_start, eng_addr, eng_owner, err_timeout, busy
  );
endinterface

// File: rtl/psram_arbiter.sv
// Two-requester PSRAM burst arbiter: req->gnt/eng_start 2 cycles, done 1 cycle after eng_done, GAP_CYCLES idle after each burst.
// Requests are sampled only in IDLE. Round-robin by default; PSRAM_ARB_FIXED_PRIO_EN gives requester 0 fixed priority.
module psram_arbiter #(
  parameter int GAP_CYCLES     = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           reset,
  psram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_e;

  localparam int MAX_CNT = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] GAP_LIM = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] TO_LIM  = CW'(TIMEOUT_CYCLES);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [21:0]   eng_addr_q, eng_addr_d;
  logic          eng_owner_q, eng_owner_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic          start_q, start_d;
  logic          err_q, err_d;
  logic          winner;

`ifdef PSRAM_ARB_FIXED_PRIO_EN
  assign winner = ~bus.req0;
`else
  logic last_owner_q, last_owner_d;

  // A lone request wins outright; a tie goes to whoever did not win last.
  assign winner = (bus.req0 && bus.req1) ? ~last_owner_q : ~bus.req0;

  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == IDLE && (bus.req0 || bus.req1)) begin
      last_owner_d = winner;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner_q <= 1'b1;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`endif

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    eng_addr_d  = eng_addr_q;
    eng_owner_d = eng_owner_q;
    gnt_d       = '0;
    done_d      = '0;
    start_d     = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d     = ISSUE;
          eng_owner_d = winner;
          eng_addr_d  = winner ? bus.addr1 : bus.addr0;
        end
      end
      ISSUE: begin
        state_d            = WAIT;
        start_d            = 1'b1;
        gnt_d[eng_owner_q] = 1'b1;
        cnt_d              = '0;
      end
      WAIT: begin
        // eng_done takes precedence over a timeout landing in the same cycle.
        if (bus.eng_done) begin
          done_d[eng_owner_q] = 1'b1;
          state_d             = GAP;
          cnt_d               = '0;
        end else if (cnt_inc >= TO_LIM) begin
          done_d[eng_owner_q] = 1'b1;
          err_d               = 1'b1;
          state_d             = GAP;
          cnt_d               = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      GAP: begin
        if (cnt_inc >= GAP_LIM) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      eng_addr_q  <= '0;
      eng_owner_q <= 1'b0;
      gnt_q       <= '0;
      done_q      <= '0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      eng_addr_q  <= eng_addr_d;
      eng_owner_q <= eng_owner_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      start_q     <= start_d;
      err_q       <= err_d;
    end
  end

  assign bus.gnt0        = gnt_q[0];
  assign bus.gnt1        = gnt_q[1];
  assign bus.done0       = done_q[0];
  assign bus.done1       = done_q[1];
  assign bus.eng_start   = start_q;
  assign bus.eng_addr    = eng_addr_q;
  assign bus.eng_owner   = eng_owner_q;
  assign bus.err_timeout = err_q;
  assign bus.busy        = (state_q != IDLE);
endmodule

// File: doc/psram_arbiter.md
PSRAM_ARBITER -- requirements
Module: psram_arbiter

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 3, giving the number of idle cycles (CE# high) enforced between bursts.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum number of cycles from eng_start to eng_done.
REQ-003 The block SHALL have port clk, input, 1 bit, the system clock; every flop SHALL be clocked on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, the reset; reset is asynchronous and active-high, and the clock is clk.
REQ-005 The block SHALL have port req0, input, 1 bit, the burst request from requester 0 (read-FIFO prefetch).
REQ-006 The block SHALL have port addr0, input, 22 bits, the burst start address from requester 0.
REQ-007 The block SHALL have port gnt0, output, 1 bit, a one-cycle pulse marking acceptance of the requester 0 request.
REQ-008 The block SHALL have port done0, output, 1 bit, a one-cycle pulse marking completion of the requester 0 burst.
REQ-009 The block SHALL have ports req1, addr1, gnt1 and done1, with the same directions, widths and meanings as the requester 0 ports, for requester 1 (MCU bridge).
REQ-010 The block SHALL have port eng_start, output, 1 bit, a one-cycle start pulse to the QPI burst engine.
REQ-011 The block SHALL have port eng_addr, output, 22 bits, the latched address of the granted request.
REQ-012 The block SHALL have port eng_owner, output, 1 bit, the index of the current owner.
REQ-013 The block SHALL have port eng_done, input, 1 bit, a one-cycle pulse from the engine when CE# has been deasserted.
REQ-014 The block SHALL have port err_timeout, output, 1 bit, a one-cycle pulse on engine timeout.
REQ-015 The block SHALL have port busy, output, 1 bit, high in every state other than IDLE.

Function
REQ-016 The state machine SHALL have exactly four states: IDLE, ISSUE, WAIT and GAP.
REQ-017 In IDLE, when req0 or req1 is sampled high, the block SHALL select the winner, latch its address into eng_addr, set eng_owner to the winner and go to ISSUE.
REQ-018 In ISSUE, the block SHALL assert eng_start and the winner's gnt for exactly one cycle, load the timeout counter with zero and go to WAIT; latency from req to gnt is 2 cycles.
REQ-019 In WAIT, when eng_done is sampled high, the block SHALL pulse done[eng_owner] on the next cycle and go to GAP.
REQ-020 In WAIT, if the counter reaches TIMEOUT_CYCLES with no eng_done, the block SHALL pulse err_timeout and done[eng_owner] in the same cycle and go to GAP.
REQ-021 In GAP, the block SHALL count GAP_CYCLES cycles and then go to IDLE; requests SHALL NOT be sampled during GAP.
REQ-022 When both requests are present, the winner SHALL be chosen by round-robin: a last_owner register starts at 1 so that requester 0 wins first, and it is updated with the winner on each grant.
REQ-023 When only one request is present, that requester SHALL win regardless of last_owner.
REQ-024 A requester SHALL hold req and addr stable until its gnt; a request withdrawn before the IDLE sample SHALL NOT be serviced and SHALL leave last_owner unchanged.
REQ-025 A request sampled high in IDLE SHALL be latched, so that dropping req during ISSUE or WAIT does not cancel the burst.
REQ-026 An eng_done seen outside WAIT SHALL be ignored.
REQ-027 A request that arrives in the same cycle as eng_done SHALL wait until GAP completes.
REQ-028 The counters SHALL saturate, never wrap, and SHALL be sized to hold max(GAP_CYCLES, TIMEOUT_CYCLES).
REQ-029 gnt0/gnt1 and done0/done1 SHALL each be mutually exclusive in every cycle.

Reset
REQ-030 When reset is asserted, the block SHALL asynchronously clear the state to IDLE and clear all pulses, busy, eng_owner, eng_addr and counters to 0, and set last_owner to 1.
REQ-031 A reset asserted mid-burst SHALL abandon that burst without any done pulse; the engine is reset by the same signal.

Configuration
REQ-032 When PSRAM_ARB_FIXED_PRIO_EN is defined, requester 0 SHALL always win a simultaneous request and last_owner SHALL be removed.
REQ-033 When PSRAM_ARB_FIXED_PRIO_EN is not defined, the block SHALL use round-robin as specified in REQ-022.

Verification
REQ-034 Bench: req0=1 with addr0=0x000020, eng_done 10 cycles after eng_start -> gnt0 and eng_start 2 cycles after req0, eng_addr=0x000020, done0 1 cycle after eng_done, busy low 3 cycles later.
REQ-035 Bench: req0 and req1 held high for 4 bursts -> grant order 0,1,0,1 (round-robin build) and 0,0,0,0 (fixed-priority build).
REQ-036 Bench: no eng_done after start -> err_timeout and done pulse exactly 255 cycles into WAIT, then a GAP of 3 cycles.
REQ-037 Bench: req1 rises in the same cycle as eng_done -> gnt1 no earlier than GAP_CYCLES+2 cycles later.
REQ-038 Bench: reset asserted during WAIT -> all outputs 0 within the same cycle, no done pulse, and the next simultaneous request is granted to requester 0.
REQ-039 Bench: req0 pulsed for 1 cycle during GAP -> no grant and last_owner unchanged.
